// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: control-vector bit
// positions, the default packed payload width and the skid-buffer state type.
package exmem_pkg;

   // Control vector layout (bit positions inside in_ctrl / out_ctrl).
   localparam int CTRL_W        = 8;
   localparam int CTRL_DMEM_WEN = 0;
   localparam int CTRL_RF_WEN   = 1;
   localparam int CTRL_BRANCH2  = 2;
   localparam int CTRL_MEM2REG  = 3;
   localparam int CTRL_S7       = 4;
   localparam int CTRL_NOP_LW   = 5;
   localparam int CTRL_NOP_SW   = 6;
   localparam int CTRL_JAL      = 7;

   // Default field widths of the EX result bundle.
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_FLAG_W  = 3;
   localparam int DEF_RADDR_W = 4;

   // Packed payload: ctrl, flags, write address and five data-wide fields
   // (alu, ext, rdata2, btgt, pc).
   function automatic int payload_width(input int data_w, input int flag_w,
                                        input int raddr_w, input int ctrl_w);
      return ctrl_w + flag_w + raddr_w + 5 * data_w;
   endfunction

   localparam int PAYLOAD_W = CTRL_W + DEF_FLAG_W + DEF_RADDR_W + 5 * DEF_DATA_W;

   // Skid buffer occupancy, encoded as {skid_v, main_v}.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_ONE   = 2'b01,
      SKID_FULL  = 2'b11
   } skid_state_e;

endpackage

// File: rtl/exmem_pipe_reg_if.sv
// EX -> MEM bundle interface.
//
// Handshake: a bundle moves across a side on a rising clk edge where both
// valid and ready are 1. The producer holds valid and payload stable until
// that edge; ready is registered on the input side and never depends
// combinationally on in_valid.
interface exmem_pipe_reg_if #(
   parameter int DATA_W  = 16,
   parameter int FLAG_W  = 3,
   parameter int RADDR_W = 4,
   parameter int CTRL_W  = 8
);

   // EX side
   logic               in_valid;
   logic               in_ready;
   logic [CTRL_W-1:0]  in_ctrl;
   logic [DATA_W-1:0]  in_alu;
   logic [FLAG_W-1:0]  in_flag;
   logic [DATA_W-1:0]  in_ext;
   logic [DATA_W-1:0]  in_rdata2;
   logic [RADDR_W-1:0] in_waddr;
   logic [DATA_W-1:0]  in_btgt;
   logic [DATA_W-1:0]  in_pc;

   // MEM side
   logic               out_valid;
   logic               out_ready;
   logic [CTRL_W-1:0]  out_ctrl;
   logic [DATA_W-1:0]  out_alu;
   logic [FLAG_W-1:0]  out_flag;
   logic [DATA_W-1:0]  out_ext;
   logic [DATA_W-1:0]  out_rdata2;
   logic [RADDR_W-1:0] out_waddr;
   logic [DATA_W-1:0]  out_btgt;
   logic [DATA_W-1:0]  out_pc;

   // Surrounding pipeline: drives EX bundle and MEM ready.
   modport master (
      output in_valid, in_ctrl, in_alu, in_flag, in_ext, in_rdata2,
             in_waddr, in_btgt, in_pc, out_ready,
      input  in_ready, out_valid, out_ctrl, out_alu, out_flag, out_ext,
             out_rdata2, out_waddr, out_btgt, out_pc
   );

   // The pipeline register itself.
   modport slave (
      input  in_valid, in_ctrl, in_alu, in_flag, in_ext, in_rdata2,
             in_waddr, in_btgt, in_pc, out_ready,
      output in_ready, out_valid, out_ctrl, out_alu, out_flag, out_ext,
             out_rdata2, out_waddr, out_btgt, out_pc
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// The main entry drives the output; the skid entry catches one bundle that
// arrives while main is stalled. in_ready is a register so the upstream
// handshake never sees a combinational path from out_ready.
module pipe_skid_buf
   import exmem_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output skid_state_e  state
);

   skid_state_e  state_q;
   skid_state_e  state_d;
   logic         ready_q;
   logic         ready_d;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;

   logic accept;
   logic issue;
   logic main_v;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   assign main_v = (state_q != SKID_EMPTY);
   assign accept = in_valid & ready_q;
   assign issue  = main_v & out_ready;

   // Next occupancy and which payload register loads from where.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;

      unique case (state_q)
         SKID_EMPTY: begin
            if (accept) begin
               state_d      = SKID_ONE;
               load_main_in = 1'b1;
            end
         end
         SKID_ONE: begin
            if (accept && issue) begin
               state_d      = SKID_ONE;
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d   = SKID_FULL;
               load_skid = 1'b1;
            end else if (issue) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            // in_ready is low here, so no accept can coincide.
            if (issue) begin
               state_d        = SKID_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_d = SKID_EMPTY;
         end
      endcase

      // Flush drops everything, including a same-cycle input; payload
      // registers keep their contents so the data outputs stay quiet.
      if (flush) begin
         state_d        = SKID_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end

      ready_d = (state_d != SKID_FULL);
   end

   // Occupancy and registered ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SKID_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   // Payload registers load only on accept or on the skid-to-main move.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

   assign in_ready = ready_q;
   assign out_data = main_q;
   assign state    = state_q;

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready flow control, flush and a
// saturating bubble counter. Packs the EX bundle into one payload for the
// skid buffer, unpacks it for MEM, and zeroes the control vector whenever
// no valid bundle is presented so no write enable or jal can leak.
module exmem_pipe_reg #(
   parameter int DATA_W  = 16,
   parameter int FLAG_W  = 3,
   parameter int RADDR_W = 4,
   parameter int CTRL_W  = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   exmem_pipe_reg_if.slave  bus,
   output logic [CNT_W-1:0] bubble_cnt
);

   import exmem_pkg::*;

   localparam int PW = payload_width(DATA_W, FLAG_W, RADDR_W, CTRL_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PW-1:0]      in_payload;
   logic [PW-1:0]      out_payload;
   skid_state_e        buf_state;
   logic               out_valid;
   logic [CNT_W-1:0]   cnt_q;

   logic [CTRL_W-1:0]  p_ctrl;
   logic [FLAG_W-1:0]  p_flag;
   logic [RADDR_W-1:0] p_waddr;
   logic [DATA_W-1:0]  p_alu;
   logic [DATA_W-1:0]  p_ext;
   logic [DATA_W-1:0]  p_rdata2;
   logic [DATA_W-1:0]  p_btgt;
   logic [DATA_W-1:0]  p_pc;

   assign in_payload = {bus.in_ctrl, bus.in_flag, bus.in_waddr, bus.in_alu,
                        bus.in_ext, bus.in_rdata2, bus.in_btgt, bus.in_pc};

   pipe_skid_buf #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_payload),
      .out_ready (bus.out_ready),
      .out_data  (out_payload),
      .state     (buf_state)
   );

   // The main entry is occupied in every state except EMPTY.
   assign out_valid = (buf_state != SKID_EMPTY);

   assign {p_ctrl, p_flag, p_waddr, p_alu,
           p_ext, p_rdata2, p_btgt, p_pc} = out_payload;

   assign bus.out_valid  = out_valid;
   assign bus.out_ctrl   = out_valid ? p_ctrl : '0;
   assign bus.out_flag   = p_flag;
   assign bus.out_waddr  = p_waddr;
   assign bus.out_alu    = p_alu;
   assign bus.out_ext    = p_ext;
   assign bus.out_rdata2 = p_rdata2;
   assign bus.out_btgt   = p_btgt;
   assign bus.out_pc     = p_pc;

   // Count cycles where MEM was ready but had nothing to take; saturate.
   // Flush deliberately leaves the count alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (bus.out_ready && !out_valid && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: directed scenarios followed by random traffic,
// all compared against a queue-based model of an in-order two-slot FIFO.
module tb_exmem_pipe_reg;

   localparam int DATA_W  = 16;
   localparam int FLAG_W  = 3;
   localparam int RADDR_W = 4;
   localparam int CTRL_W  = 8;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [CTRL_W-1:0]  ctrl;
      logic [FLAG_W-1:0]  flag;
      logic [RADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  alu;
      logic [DATA_W-1:0]  ext;
      logic [DATA_W-1:0]  rdata2;
      logic [DATA_W-1:0]  btgt;
      logic [DATA_W-1:0]  pc;
   } bundle_t;

   // ---------------- clock / reset / DUT ----------------
   logic             clk;
   logic             rst_n;
   logic             flush;
   logic [CNT_W-1:0] bubble_cnt;

   exmem_pipe_reg_if #(
      .DATA_W (DATA_W), .FLAG_W (FLAG_W), .RADDR_W (RADDR_W), .CTRL_W (CTRL_W)
   ) bus_if ();

   exmem_pipe_reg #(
      .DATA_W (DATA_W), .FLAG_W (FLAG_W), .RADDR_W (RADDR_W),
      .CTRL_W (CTRL_W), .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus_if),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bundle_t exp_q[$];     // bundles held by the stage, oldest first
   bundle_t shown;        // payload visible on the data outputs
   bundle_t cur_in;       // bundle currently driven on in_*
   logic    m_ready;
   int      m_cnt;

   int checks;
   int failures;

   // ---------------- driver tasks ----------------
   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.ctrl   = CTRL_W'($urandom);
      b.flag   = FLAG_W'($urandom);
      b.waddr  = RADDR_W'($urandom);
      b.alu    = DATA_W'($urandom);
      b.ext    = DATA_W'($urandom);
      b.rdata2 = DATA_W'($urandom);
      b.btgt   = DATA_W'($urandom);
      b.pc     = DATA_W'($urandom);
      return b;
   endfunction

   task automatic drive(input bundle_t b, input logic v);
      cur_in           = b;
      bus_if.in_valid  = v;
      bus_if.in_ctrl   = b.ctrl;
      bus_if.in_flag   = b.flag;
      bus_if.in_waddr  = b.waddr;
      bus_if.in_alu    = b.alu;
      bus_if.in_ext    = b.ext;
      bus_if.in_rdata2 = b.rdata2;
      bus_if.in_btgt   = b.btgt;
      bus_if.in_pc     = b.pc;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic check_all();
      logic busy;
      busy = (exp_q.size() > 0);
      chk("out_valid",  32'(bus_if.out_valid),  32'(busy));
      chk("in_ready",   32'(bus_if.in_ready),   32'(m_ready));
      chk("out_ctrl",   32'(bus_if.out_ctrl),   busy ? 32'(shown.ctrl) : 32'd0);
      chk("out_flag",   32'(bus_if.out_flag),   32'(shown.flag));
      chk("out_waddr",  32'(bus_if.out_waddr),  32'(shown.waddr));
      chk("out_alu",    32'(bus_if.out_alu),    32'(shown.alu));
      chk("out_ext",    32'(bus_if.out_ext),    32'(shown.ext));
      chk("out_rdata2", 32'(bus_if.out_rdata2), 32'(shown.rdata2));
      chk("out_btgt",   32'(bus_if.out_btgt),   32'(shown.btgt));
      chk("out_pc",     32'(bus_if.out_pc),     32'(shown.pc));
      chk("bubble_cnt", 32'(bubble_cnt),        32'(m_cnt));
   endtask

   // Advance the model by one clock using the inputs as currently driven,
   // then let the DUT take the same edge and compare after it settles.
   task automatic tick();
      logic busy;
      logic issue;
      logic accept;
      if (!rst_n) begin
         exp_q.delete();
         shown   = '0;
         m_cnt   = 0;
         m_ready = 1'b1;
      end else begin
         busy   = (exp_q.size() > 0);
         issue  = busy && bus_if.out_ready;
         accept = bus_if.in_valid && m_ready;
         if (bus_if.out_ready && !busy && m_cnt < CNT_MAX) m_cnt++;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (issue) void'(exp_q.pop_front());
            if (accept) exp_q.push_back(cur_in);
         end
         if (exp_q.size() > 0) shown = exp_q[0];
         m_ready = (exp_q.size() < 2);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bundle_t b;
      checks   = 0;
      failures = 0;
      shown    = '0;
      m_cnt    = 0;
      m_ready  = 1'b1;
      rst_n    = 1'b0;
      flush    = 1'b0;
      bus_if.out_ready = 1'b0;
      drive('0, 1'b0);

      // Reset for two cycles.
      tick();
      tick();
      rst_n = 1'b1;

      // 1. Stream four bundles with MEM always ready.
      bus_if.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         b = rand_bundle();
         b.alu = DATA_W'(i);
         drive(b, 1'b1);
         tick();
         chk("t1_alu", 32'(bus_if.out_alu), 32'(i));
         chk("t1_ready", 32'(bus_if.in_ready), 32'd1);
      end
      drive(rand_bundle(), 1'b0);
      tick();

      // 2. Backpressure: ONE holding 0xAA, accept 0xBB while stalled.
      bus_if.out_ready = 1'b0;
      b = rand_bundle(); b.alu = 16'h00AA;
      drive(b, 1'b1);
      tick();
      b = rand_bundle(); b.alu = 16'h00BB;
      drive(b, 1'b1);
      tick();
      chk("t2_full_ready", 32'(bus_if.in_ready), 32'd0);
      chk("t2_full_alu", 32'(bus_if.out_alu), 32'h00AA);
      drive(rand_bundle(), 1'b0);
      bus_if.out_ready = 1'b1;
      tick();
      chk("t2_second_alu", 32'(bus_if.out_alu), 32'h00BB);
      chk("t2_ready_back", 32'(bus_if.in_ready), 32'd1);
      tick();

      // 3. Flush while FULL with a competing input.
      bus_if.out_ready = 1'b0;
      b = rand_bundle(); b.alu = 16'h0011; drive(b, 1'b1); tick();
      b = rand_bundle(); b.alu = 16'h0022; drive(b, 1'b1); tick();
      b = rand_bundle(); b.alu = 16'h00CC; drive(b, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_valid", 32'(bus_if.out_valid), 32'd0);
      chk("t3_ctrl", 32'(bus_if.out_ctrl), 32'd0);
      chk("t3_ready", 32'(bus_if.in_ready), 32'd1);
      drive(rand_bundle(), 1'b0);
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_no_cc", 32'(bus_if.out_alu == 16'h00CC), 32'd0);
      end

      // 4. Control masking once the bundle has issued.
      b = rand_bundle(); b.ctrl = 8'hFF; b.alu = 16'h5A5A;
      drive(b, 1'b1);
      tick();
      chk("t4_ctrl_live", 32'(bus_if.out_ctrl), 32'hFF);
      drive(rand_bundle(), 1'b0);
      tick();
      chk("t4_ctrl_masked", 32'(bus_if.out_ctrl), 32'd0);
      chk("t4_alu_held", 32'(bus_if.out_alu), 32'h5A5A);

      // 5. Counter saturation, immune to flush, cleared by reset.
      for (int i = 0; i < 20; i++) tick();
      chk("t5_sat", 32'(bubble_cnt), 32'd15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush_keeps", 32'(bubble_cnt), 32'd15);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_reset_clears", 32'(bubble_cnt), 32'd0);

      // 6. Reset beats flush and input while FULL.
      bus_if.out_ready = 1'b0;
      drive(rand_bundle(), 1'b1); tick();
      drive(rand_bundle(), 1'b1); tick();
      drive(rand_bundle(), 1'b1);
      flush = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      flush = 1'b0;
      drive(rand_bundle(), 1'b0);
      chk("t6_valid", 32'(bus_if.out_valid), 32'd0);
      chk("t6_ready", 32'(bus_if.in_ready), 32'd1);
      chk("t6_alu_zero", 32'(bus_if.out_alu), 32'd0);
      chk("t6_pc_zero", 32'(bus_if.out_pc), 32'd0);
      chk("t6_cnt_zero", 32'(bubble_cnt), 32'd0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive(rand_bundle(), 1'($urandom_range(0, 3) != 0));
         bus_if.out_ready = 1'($urandom_range(0, 3) != 0);
         flush = 1'($urandom_range(0, 19) == 0);
         tick();
      end
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised successor to the fixed EX/MEM latch. It carries the EX-stage result bundle (ALU result, flags, store data, write address, extended immediate, branch target, PC+1, control bits) into MEM. It adds valid/ready flow control with a 2-entry skid buffer, synchronous flush (bubble insertion), and a saturating bubble counter for performance monitoring. It sits between the EX datapath and the data-memory/writeback logic.

Parameters:
DATA_W, 16, width of aluout, rdata2, extended, branch target and pc_added fields
FLAG_W, 3, width of ALU flag field
RADDR_W, 4, register-file write-address width
CTRL_W, 8, control vector width; bit order fixed in package: 0 dmem_wen, 1 rf_wen, 2 branch2, 3 mem2reg, 4 s7, 5 nop_lw, 6 nop_sw, 7 jal
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  EX bundle valid
in_ready  out  1  stage can accept; registered
in_ctrl  in  CTRL_W  control vector
in_alu  in  DATA_W  ALU result
in_flag  in  FLAG_W  ALU flags
in_ext  in  DATA_W  extended immediate
in_rdata2  in  DATA_W  store data
in_waddr  in  RADDR_W  RF write address
in_btgt  in  DATA_W  branch target
in_pc  in  DATA_W  PC+1 (jal link value)
flush  in  1  discard all held and incoming entries
out_valid  out  1  MEM bundle valid
out_ready  in  1  MEM stage accepts
out_ctrl, out_alu, out_flag, out_ext, out_rdata2, out_waddr, out_btgt, out_pc  out  as inputs  held bundle
bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset (rst_n=0 at posedge): main_v=0, skid_v=0, all payload regs 0, bubble_cnt=0, in_ready=1. Outputs reflect zeroed registers from the next cycle.
- Transfer rules: accept = in_valid & in_ready; issue = out_valid & out_ready.
- Storage: main entry drives the outputs; skid entry catches one bundle when main stalls. out_valid=main_v. in_ready is a register equal to !skid_v of the next state.
- States, encoded by {skid_v, main_v}:
  - EMPTY: accept → ONE.
  - ONE: accept & issue → ONE with main loaded from input. Accept & !issue → FULL, input goes to skid. Issue & !accept → EMPTY.
  - FULL: in_ready=0. Issue → ONE, skid moves to main. No issue → hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 bundle/cycle while out_ready stays high.
- Bubble masking: whenever out_valid=0, out_ctrl is forced to all-zero, so no dmem_wen/rf_wen/jal can leak. Data outputs hold their last value.
- Flush: at posedge with flush=1, main_v=skid_v=0 and in_ready=1. Any same-cycle input is discarded, so flush beats accept. A same-cycle issue still counts as completed by downstream.
- Flush and reset together: reset wins, and bubble_cnt is cleared.
- bubble_cnt: increments when out_ready=1 & out_valid=0. Saturates at 2^CNT_W-1 with no wrap. Flush does not clear it.
- Payload registers load only on an accept or a skid→main move. There is no combinational path from in_* to out_*. The only combinational path from out_ready is into the internal next-state logic.

Decomposition:
- Package exmem_pkg holds:
  - ctrl bit index constants (CTRL_DMEM_WEN … CTRL_JAL), CTRL_W.
  - a localparam for the packed payload width: CTRL_W + FLAG_W + RADDR_W + 5*DATA_W.
- One sub-module, pipe_skid_buf: generic two-entry valid/ready skid buffer parametrised by payload width, with flush.
- The top level packs and unpacks the fields, applies ctrl masking and owns bubble_cnt.

Test Plan:
1. Reset then stream: rst_n low 2 cycles, then in_valid=1 for 4 cycles with in_alu=0x0001..0x0004 and out_ready=1. Required: out_valid rises 1 cycle after the first accept; out_alu=1,2,3,4 on consecutive cycles; in_ready stays 1.
2. Backpressure: ONE state holding alu 0x00AA, out_ready=0, new in_alu=0x00BB accepted. Required: next cycle in_ready=0 and out_alu=0x00AA. With out_ready=1, 0x00AA then 0x00BB issue, and in_ready returns to 1.
3. Flush in FULL: flush=1 with in_valid=1 (alu 0x00CC). Required: next cycle out_valid=0, out_ctrl=0x00, in_ready=1; 0x00CC never appears.
4. Bubble masking: accept ctrl=0xFF, issue it, no new input. Required: out_ctrl=0x00 once out_valid=0 while out_alu holds its value.
5. Counter saturation: CNT_W=4, out_ready=1, no input for 20 cycles. Required: bubble_cnt reaches 15 and holds; a flush leaves it at 15; reset clears it to 0.
6. Reset mid-operation: FULL state, rst_n=0 with flush=1 and in_valid=1. Required: next cycle out_valid=0, in_ready=1, all outputs 0, bubble_cnt=0.
